// File: rtl/firmware_cpu_mul_pkg.sv
// Shared constants, op encodings and sequencer states for the multiply combine stage.
package firmware_cpu_mul_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HIMUL = 2'b01,
    FIX   = 2'b10,
    DONE  = 2'b11
  } mul_state_e;

endpackage

// File: rtl/firmware_cpu_mul_hihi_seq.sv
// Iterative 16x16 unsigned shift-add multiplier for the hi*hi partial product.
// One multiplier bit per cycle, LSB first; done is high during the final iteration.
module firmware_cpu_mul_hihi_seq #(
  parameter int HALF_W   = 16,
  parameter int HI_ITERS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [HALF_W-1:0]     a,
  input  logic [HALF_W-1:0]     b,
  output logic                  done,
  output logic [2*HALF_W-1:0]   product
);
  import firmware_cpu_mul_pkg::*;

  localparam int CNT_W = $clog2(HI_ITERS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HI_ITERS - 1);

  logic [2*HALF_W-1:0] mcand_reg;
  logic [2*HALF_W-1:0] acc_reg;
  logic [HALF_W-1:0]   mplier_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                busy_reg;

  assign done    = busy_reg && (cnt_reg == LAST);
  assign product = acc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{HALF_W{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      if (mplier_reg[0]) begin
        acc_reg <= acc_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/firmware_cpu_mul_combine.sv
// Combines registered 16x16 partial products into the 32-bit MUL result.
// Define FIRMWARE_CPU_MULX_EN to add the MULXUU/MULXSU/MULXSS high-word path.
module firmware_cpu_mul_combine #(
  parameter int DATA_W   = 32,
  parameter int HI_ITERS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [1:0]        m_op,
  input  logic [DATA_W-1:0] m_p1,
  input  logic [DATA_W-1:0] m_p2,
  input  logic [DATA_W-1:0] m_p3,
  input  logic [DATA_W-1:0] m_src1,
  input  logic [DATA_W-1:0] m_src2,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] a_result
);
  import firmware_cpu_mul_pkg::*;

  localparam int HALF_W = DATA_W / 2;

  logic [DATA_W:0] mid;
  logic [DATA_W:0] lo_sum;
  logic            accept;
  logic            drain;

  assign mid    = {1'b0, m_p2} + {1'b0, m_p3};
  assign lo_sum = {1'b0, m_p1} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
  assign accept = m_valid && m_ready;
  assign drain  = a_valid && a_ready;

`ifdef FIRMWARE_CPU_MULX_EN
  mul_state_e          state_reg, state_next;
  mul_op_e             op_reg;
  logic [DATA_W-1:0]   src1_reg;
  logic [DATA_W-1:0]   src2_reg;
  logic [HALF_W:0]     mid_hi_reg;
  logic                carry_reg;
  logic                is_mulx;
  logic                seq_start;
  logic                seq_done;
  logic [DATA_W-1:0]   seq_product;
  logic [DATA_W-1:0]   high_u;
  logic [DATA_W-1:0]   high_fix;
  logic                sub_src2;
  logic                sub_src1;

  assign is_mulx = (m_op != OP_MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_ready    = 1'b0;
    seq_start  = 1'b0;
    case (state_reg)
      IDLE: begin
        m_ready = ~a_valid | a_ready;
        if (m_valid && m_ready && is_mulx) begin
          seq_start  = 1'b1;
          state_next = HIMUL;
        end
      end
      HIMUL: if (seq_done) state_next = FIX;
      FIX:   state_next = DONE;
      DONE:  if (a_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed forms are recovered from the unsigned product by subtracting the other operand.
  assign sub_src2 = ((op_reg == OP_MULXSU) || (op_reg == OP_MULXSS)) && src1_reg[DATA_W-1];
  assign sub_src1 = (op_reg == OP_MULXSS) && src2_reg[DATA_W-1];
  assign high_u   = seq_product + DATA_W'(mid_hi_reg) + DATA_W'(carry_reg);
  assign high_fix = high_u - (sub_src2 ? src2_reg : '0) - (sub_src1 ? src1_reg : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg     <= OP_MUL;
      src1_reg   <= '0;
      src2_reg   <= '0;
      mid_hi_reg <= '0;
      carry_reg  <= 1'b0;
    end else if (seq_start) begin
      op_reg     <= mul_op_e'(m_op);
      src1_reg   <= m_src1;
      src2_reg   <= m_src2;
      mid_hi_reg <= mid[DATA_W:HALF_W];
      carry_reg  <= lo_sum[DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid  <= 1'b0;
      a_result <= '0;
    end else begin
      if (drain) begin
        a_valid <= 1'b0;
      end
      if (accept && !is_mulx) begin
        a_valid  <= 1'b1;
        a_result <= lo_sum[DATA_W-1:0];
      end else if (state_reg == FIX) begin
        a_valid  <= 1'b1;
        a_result <= high_fix;
      end
    end
  end

  firmware_cpu_mul_hihi_seq #(
    .HALF_W   (HALF_W),
    .HI_ITERS (HI_ITERS)
  ) u_hihi_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .a       (m_src1[DATA_W-1:HALF_W]),
    .b       (m_src2[DATA_W-1:HALF_W]),
    .done    (seq_done),
    .product (seq_product)
  );
`else
  logic unused_inputs;

  // The MULX operands stay on the port list so both builds share one interface.
  assign unused_inputs = ^{m_op, m_src1, m_src2, mid[DATA_W:HALF_W], lo_sum[DATA_W], HI_ITERS[0]};
  assign m_ready       = ~a_valid | a_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid  <= 1'b0;
      a_result <= '0;
    end else begin
      if (drain) begin
        a_valid <= 1'b0;
      end
      if (accept) begin
        a_valid  <= 1'b1;
        a_result <= lo_sum[DATA_W-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_firmware_cpu_mul_combine.sv
// Self-checking bench for firmware_cpu_mul_combine: full-product reference model plus directed literals.
module tb_firmware_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_ready;
  logic [1:0]  m_op = 2'b00;
  logic [31:0] m_p1 = '0, m_p2 = '0, m_p3 = '0, m_src1 = '0, m_src2 = '0;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [31:0] a_result;

  int checks = 0;
  int errors = 0;

`ifdef FIRMWARE_CPU_MULX_EN
  localparam bit MULX_EN = 1'b1;
`else
  localparam bit MULX_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  firmware_cpu_mul_combine dut (
    .clk      (clk),
    .reset    (reset),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_op     (m_op),
    .m_p1     (m_p1),
    .m_p2     (m_p2),
    .m_p3     (m_p3),
    .m_src1   (m_src1),
    .m_src2   (m_src2),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_result (a_result)
  );

  // ---------------- reference model ----------------
  bit          exp_valid = 1'b0;
  bit          exp_mulx = 1'b0;
  logic [31:0] exp_result = '0;
  logic [31:0] hold_hi = '0;
  int          countdown = 0;
  bit          acc_now;

  function automatic logic [31:0] ref_low(input logic [31:0] s1, input logic [31:0] s2);
    logic [63:0] p;
    p = {32'h0, s1} * {32'h0, s2};
    return p[31:0];
  endfunction

  function automatic logic [31:0] ref_high(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2);
    longint a, b;
    logic [63:0] p;
    a = op[1] ? longint'($signed(s1)) : longint'({32'h0, s1});
    b = (op == 2'b11) ? longint'($signed(s2)) : longint'({32'h0, s2});
    p = a * b;
    return p[63:32];
  endfunction

  function automatic bit exp_ready();
    return (countdown == 0) && !(exp_valid && exp_mulx) && (!exp_valid || a_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_valid  = 1'b0;
      exp_mulx   = 1'b0;
      exp_result = '0;
      countdown  = 0;
    end else begin
      acc_now = m_valid && exp_ready();
      if (exp_valid && a_ready) begin
        exp_valid = 1'b0;
        exp_mulx  = 1'b0;
      end
      if (countdown > 0) begin
        countdown = countdown - 1;
        if (countdown == 0) begin
          exp_valid  = 1'b1;
          exp_mulx   = 1'b1;
          exp_result = hold_hi;
        end
      end
      if (acc_now) begin
        if (!MULX_EN || m_op == 2'b00) begin
          exp_valid  = 1'b1;
          exp_mulx   = 1'b0;
          exp_result = ref_low(m_src1, m_src2);
        end else begin
          countdown = 17;
          hold_hi   = ref_high(m_op, m_src1, m_src2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_valid", {31'h0, a_valid}, {31'h0, exp_valid});
    chk("m_ready", {31'h0, m_ready}, {31'h0, exp_ready()});
    if (exp_valid) chk("a_result", a_result, exp_result);
    if (reset) chk("reset_result", a_result, exp_result);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2);
    m_valid = 1'b1;
    m_op    = op;
    m_src1  = s1;
    m_src2  = s2;
    m_p1    = 32'(s1[15:0]) * 32'(s2[15:0]);
    m_p2    = 32'(s1[15:0]) * 32'(s2[31:16]);
    m_p3    = 32'(s1[31:16]) * 32'(s2[15:0]);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2);
    int n;
    bit ok;
    drive(op, s1, s2);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = m_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d cycles required=accept", n);
    end
    #2;
    m_valid = 1'b0;
    m_op    = 2'($urandom);
    m_p1    = $urandom;
    m_p2    = $urandom;
    m_p3    = $urandom;
    m_src1  = $urandom;
    m_src2  = $urandom;
    $display("txn op=%0d src1=%08h src2=%08h accepted after %0d cycles", op, s1, s2, n);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_valid && n < 100);
  endtask

  logic [1:0]  tab_op [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
  logic [31:0] tab_s1 [6] = '{32'h12345678, 32'h80000001, 32'hFFFF0000, 32'h7FFFFFFF, 32'h80000000, 32'h0000FFFF};
  logic [31:0] tab_s2 [6] = '{32'h9ABCDEF0, 32'hFFFFFFFF, 32'h0001FFFF, 32'h80000000, 32'h80000000, 32'h0000FFFF};

  initial begin
    int lat;
    @(negedge clk);
    chk("rst_a_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_m_ready", {31'h0, m_ready}, 32'h1);
    chk("rst_a_result", a_result, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Basic MUL, latency 1
    send(2'b00, 32'h00010003, 32'h00020005);
    @(negedge clk);
    chk("mul_basic_valid", {31'h0, a_valid}, 32'h1);
    chk("mul_basic_result", a_result, 32'h000B000F);
    tick();

    // Back-pressure with a second request pending
    a_ready = 1'b0;
    send(2'b00, 32'h00000007, 32'h00000009);
    drive(2'b00, 32'h00030000, 32'h00000004);
    repeat (3) begin
      @(negedge clk);
      chk("hold_result", a_result, 32'h0000003F);
      chk("hold_ready", {31'h0, m_ready}, 32'h0);
    end
    tick();
    a_ready = 1'b1;
    @(negedge clk);
    chk("drain_ready", {31'h0, m_ready}, 32'h1);
    tick();
    m_valid = 1'b0;
    @(negedge clk);
    chk("second_result", a_result, 32'h000C0000);
    tick();

    // op=11 with all-ones operands
    send(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
`ifdef FIRMWARE_CPU_MULX_EN
    chk("mulxss_latency", lat, 18);
    chk("mulxss_result", a_result, 32'h00000000);
    tick();
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    chk("mulxuu_latency", lat, 18);
    chk("mulxuu_result", a_result, 32'hFFFFFFFE);
    tick();
    send(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    chk("mulxsu_result", a_result, 32'hFFFFFFFF);
`else
    chk("op11_latency", lat, 1);
    chk("op11_low_word", a_result, 32'h00000001);
`endif
    tick();

    // Back-to-back stream
    foreach (tab_op[i]) send(tab_op[i], tab_s1[i], tab_s2[i]);
    repeat (20) tick();

    // Reset in the middle of an operation
`ifdef FIRMWARE_CPU_MULX_EN
    send(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (8) tick();
`else
    a_ready = 1'b0;
    send(2'b00, 32'h00010003, 32'h00020005);
`endif
    reset = 1'b1;
    #1;
    chk("abort_a_valid", {31'h0, a_valid}, 32'h0);
    chk("abort_m_ready", {31'h0, m_ready}, 32'h1);
    tick();
    reset   = 1'b0;
    a_ready = 1'b1;
    tick();
    send(2'b00, 32'h00010003, 32'h00020005);
    @(negedge clk);
    chk("post_reset_result", a_result, 32'h000B000F);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
